// File: rtl/fasrip_seq_ctrl.sv
// Nibble-serial wide add/subtract sequencer around one 4-bit fasrip ripple slice.
// Operands are latched on accept, walked LSB nibble first, and the result is held until taken.

module fasrip (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       s_op,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] w_bx;
  logic [4:0] w_c;

  assign w_bx   = b ^ {4{s_op}};
  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]     = a[i] ^ w_bx[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & w_bx[i]) | (w_c[i] & (a[i] ^ w_bx[i]));
  end

  assign cout = w_c[4];
endmodule

module fasrip_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_res,
  output logic                 out_carry,
  output logic                 out_ovf
);
  localparam int         W     = 4 * NIBBLES;
  localparam logic [2:0] KLAST = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_op;
  logic [2:0]     r_k;
  logic           r_carry;
  logic [W-1:0]   r_res;
  logic           r_ovf;

  logic [3:0]     w_a_nib;
  logic [3:0]     w_b_nib;
  logic           w_cin;
  logic [3:0]     w_s;
  logic           w_cout;
  logic           w_last;

  assign w_a_nib = 4'(r_a >> {r_k, 2'b00});
  assign w_b_nib = 4'(r_b >> {r_k, 2'b00});
  // The first nibble takes op as carry-in so subtraction becomes A + ~B + 1.
  assign w_cin   = (r_k == 3'd0) ? r_op : r_carry;
  assign w_last  = (r_k == KLAST);

  fasrip u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (w_cin),
    .s_op (r_op),
    .s    (w_s),
    .cout (w_cout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_k     <= 3'd0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a  <= in_a;
            r_b  <= in_b;
            r_op <= in_op;
            r_k  <= 3'd0;
          end
        end
        S_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (r_k == 3'(n)) r_res[4*n +: 4] <= w_s;
          end
          r_carry <= w_cout;
          r_k     <= r_k + 3'd1;
          // Sign bit of the result is this cycle's slice MSB on the last nibble.
          if (w_last)
            r_ovf <= (r_a[W-1] == (r_b[W-1] ^ r_op)) && (w_s[3] != r_a[W-1]);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_res   = r_res;
  assign out_carry = r_carry;
  assign out_ovf   = r_ovf;
endmodule
